alu_mdu_seq: RTL and testbench
==============================

ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values are even and 8..64.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to launch an operation this cycle.
REQ-005 SHALL have port ALUOp, input, 2, Controller opcode field; 2'b10 = R-type.
REQ-006 SHALL have port Funct7, input, 7, instruction bits 31:25.
REQ-007 SHALL have port Funct3, input, 3, instruction bits 14:12, selecting the M-extension operation.
REQ-008 SHALL have port SrcA, input, WIDTH, rs1 operand (multiplicand/dividend).
REQ-009 SHALL have port SrcB, input, WIDTH, rs2 operand (multiplier/divisor).
REQ-010 SHALL have port Busy, output, 1, high while an operation is iterating; pipeline stall source.
REQ-011 SHALL have port Done, output, 1, one-cycle pulse marking Result valid.
REQ-012 SHALL have port Result, output, WIDTH, operation result, held until the next accepted operation.

Function
REQ-013 SHALL accept an operation on a rising edge only when start=1, state=IDLE, ALUOp=2'b10 and Funct7=7'b0000001; otherwise start is ignored.
REQ-014 SHALL latch SrcA, SrcB and Funct3 at acceptance; later input changes SHALL NOT affect the operation.
REQ-015 SHALL decode Funct3: 000 MUL (low WIDTH bits), 001 MULH (signed x signed, high), 010 MULHSU (signed SrcA x unsigned SrcB, high), 011 MULHU (unsigned, high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-016 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-017 SHALL, on acceptance of a normal operation, move IDLE->CALC, load an iteration counter with WIDTH-1 and process one operand bit per cycle (shift-add multiply, restoring divide on magnitudes).
REQ-018 SHALL move CALC->DONE on the cycle the counter reaches 0, giving exactly WIDTH cycles in CALC.
REQ-019 SHALL move DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL drive Busy=1 exactly in CALC and Done=1 exactly in DONE; for normal operations Done is high in the (WIDTH+1)-th cycle after the accepting edge.
REQ-021 SHALL apply sign correction after iteration: DIV quotient is negative iff the operand signs differ; REM takes the sign of the dividend; high products of signed forms use two's-complement correction of the 2*WIDTH product.
REQ-022 SHALL treat a divisor of 0 as a special case that goes IDLE->DONE directly (Done one cycle after acceptance): DIV/DIVU give all ones, REM/REMU give SrcA.
REQ-023 SHALL treat DIV/REM with SrcA = most-negative value and SrcB = all ones as a special case that goes IDLE->DONE directly: DIV gives SrcA, REM gives 0.
REQ-024 SHALL update Result only on entering DONE; Result SHALL hold its value in IDLE and CALC.
REQ-025 SHALL ignore start asserted in CALC or DONE; a start in the cycle that the FSM is in DONE SHALL NOT be accepted (earliest re-accept is in IDLE).

Reset
REQ-026 SHALL, with reset=1 at a rising edge, force state=IDLE, counter=0, Busy=0, Done=0, Result=0, regardless of the current state.
REQ-027 SHALL discard any in-flight operation on reset without asserting Done; reset SHALL take priority over start in the same cycle.

Verification
REQ-028 SHALL cover this case (WIDTH=32): MUL SrcA=7, SrcB=6 -> Busy high 32 cycles, Done pulse in cycle 33 after acceptance, Result=42.
REQ-029 SHALL cover this case: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-030 SHALL cover this case: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, and REMU of the same operands -> 2.
REQ-031 SHALL cover this case: DIVU 5/0 -> Done one cycle after acceptance with Result=0xFFFFFFFF, Busy never high; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-032 SHALL cover this case: reset asserted in the 10th CALC cycle -> next cycle IDLE, Busy=0, Done=0, Result=0, with no Done pulse.
REQ-033 SHALL cover this case: start held high during CALC with new operands, and start with Funct7=0000000 in IDLE -> neither is accepted and the original Result is unchanged.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Sequential RV32M-style multiply/divide unit: one operand bit per cycle.
// It shift-adds for multiply and does a restoring divide on magnitudes, with sign fix-up on exit.
module alu_mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [2:0] fn;
    logic       neg_q;   // product sign (mul) or quotient sign (div)
    logic       neg_r;   // remainder sign = dividend sign
  } op_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  op_t                op;
  logic [2*WIDTH-1:0] p;    // {acc/remainder, multiplier/quotient}
  logic [WIDTH-1:0]   opb;  // multiplicand or divisor magnitude

  // ---------------- acceptance decode ----------------
  logic             accept, is_div, a_sgn, b_sgn, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  always_comb begin
    accept   = start && (state == IDLE) && (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    is_div   = Funct3[2];
    a_sgn    = SrcA[WIDTH-1] && (Funct3 == 3'b001 || Funct3 == 3'b010 ||
                                 Funct3 == 3'b100 || Funct3 == 3'b110);
    b_sgn    = SrcB[WIDTH-1] && (Funct3 == 3'b001 || Funct3 == 3'b100 || Funct3 == 3'b110);
    a_mag    = a_sgn ? -SrcA : SrcA;
    b_mag    = b_sgn ? -SrcB : SrcB;
    div_zero = is_div && (SrcB == '0);
    div_ovf  = is_div && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    special_res = '0;
    if (div_zero)     special_res = Funct3[1] ? SrcA : '1;
    else if (div_ovf) special_res = Funct3[1] ? '0 : SrcA;
  end

  // ---------------- one iteration step ----------------
  logic [WIDTH:0]     madd, rsh, rsub;
  logic [2*WIDTH-1:0] p_nxt;

  always_comb begin
    madd = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb} : '0);
    rsh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    rsub = rsh - {1'b0, opb};
    if (op.fn[2]) begin
      // Remainder stays below the divisor, so bit WIDTH of rsub is a clean borrow.
      if (rsub[WIDTH]) p_nxt = {rsh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      else             p_nxt = {rsub[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end else begin
      p_nxt = {madd, p[WIDTH-1:1]};
    end
  end

  // ---------------- sign fix-up of the final step ----------------
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, final_res;

  always_comb begin
    prod = op.neg_q ? -p_nxt : p_nxt;
    quo  = op.neg_q ? -p_nxt[WIDTH-1:0] : p_nxt[WIDTH-1:0];
    rem  = op.neg_r ? -p_nxt[2*WIDTH-1:WIDTH] : p_nxt[2*WIDTH-1:WIDTH];
    case (op.fn)
      3'b000:         final_res = prod[WIDTH-1:0];
      3'b100, 3'b101: final_res = quo;
      3'b110, 3'b111: final_res = rem;
      default:        final_res = prod[2*WIDTH-1:WIDTH];
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
      op     <= '0;
      p      <= '0;
      opb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (accept) begin
            op.fn    <= Funct3;
            op.neg_q <= a_sgn ^ b_sgn;
            op.neg_r <= a_sgn;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              Done   <= 1'b1;
              Result <= special_res;
            end else begin
              state <= CALC;
              Busy  <= 1'b1;
              cnt   <= CW'(WIDTH - 1);
              opb   <= is_div ? b_mag : a_mag;
              p     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            end
          end
        end
        CALC: begin
          p <= p_nxt;
          if (cnt == '0) begin
            state  <= DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            Result <= final_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq (WIDTH=32): results, latency, specials, reset abort, ignored starts.
module tb_alu_mdu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   ALUOp;
  logic [6:0]   Funct7;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB, Result;
  logic         Busy, Done;

  int n_test = 0;
  int n_fail = 0;

  alu_mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Count cycles from the accepting edge until Done (cycle 1 = first negedge after it).
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!Done && lat < 100) begin
      if (Busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int lat, busy_n;
    @(negedge clk);
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = f3; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
    wait_done(lat, busy_n);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(busy_n), 64'((exp_lat == 1) ? 0 : W));
    chk(tag, Result, exp);
    @(negedge clk);
    chk({tag, "_hold"}, {Done, Busy, Result}, {2'b00, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n, dones;
    reset = 1'b1; start = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {Busy, Done, Result}, 34'h0);
    reset = 1'b0;

    op("mul_7x6",        3'b000, 32'd7,          32'd6,          32'd42,         W + 1);
    op("mul_neg",        3'b000, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   W + 1);
    op("mulh_m1m1",      3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   W + 1);
    op("mulhu_m1m1",     3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   W + 1);
    op("mulhsu_m1x2",    3'b010, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF,   W + 1);
    op("mulh_minmin",    3'b001, 32'h80000000,   32'h80000000,   32'h40000000,   W + 1);
    op("div_m7_2",       3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   W + 1);
    op("rem_m7_2",       3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   W + 1);
    op("divu_100_7",     3'b101, 32'd100,        32'd7,          32'd14,         W + 1);
    op("remu_100_7",     3'b111, 32'd100,        32'd7,          32'd2,          W + 1);
    op("div_20_m3",      3'b100, 32'd20,         32'hFFFFFFFD,   32'hFFFFFFFA,   W + 1);
    op("rem_20_m3",      3'b110, 32'd20,         32'hFFFFFFFD,   32'd2,          W + 1);
    op("divu_min_m1",    3'b101, 32'h80000000,   32'hFFFFFFFF,   32'd0,          W + 1);
    op("remu_min_m1",    3'b111, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   W + 1);
    op("divu_5_0",       3'b101, 32'd5,          32'd0,          32'hFFFFFFFF,   1);
    op("rem_5_0",        3'b110, 32'd5,          32'd0,          32'd5,          1);
    op("div_ovf",        3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1);
    op("rem_ovf",        3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1);

    // Reset in the 10th CALC cycle aborts the operation with no Done pulse.
    @(negedge clk);
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_pre", 64'(Busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {Busy, Done, Result}, 34'h0);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done || Busy) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);

    // Start held through CALC and DONE with new operands must not relaunch.
    @(negedge clk);
    start = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b000; SrcA = 32'd7; SrcB = 32'd6;
    @(negedge clk);
    SrcA = 32'd100; SrcB = 32'd100; Funct3 = 3'b011;
    wait_done(lat, busy_n);
    chk("hold_start_lat", 64'(lat), 64'(W + 1));
    chk("hold_start_res", Result, 32'd42);
    @(negedge clk);
    start = 1'b0;
    chk("no_accept_in_done", {Busy, Done}, 2'b00);
    @(negedge clk);
    chk("no_accept_in_done2", {Busy, Done, Result}, {2'b00, 32'd42});

    // Non-M instructions in IDLE are ignored.
    start = 1'b1; Funct7 = 7'h00; ALUOp = 2'b10;
    repeat (3) @(negedge clk);
    chk("funct7_zero_ignored", {Busy, Done, Result}, {2'b00, 32'd42});
    Funct7 = 7'h01; ALUOp = 2'b00;
    repeat (3) @(negedge clk);
    chk("aluop_ignored", {Busy, Done, Result}, {2'b00, 32'd42});
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
